// File: rtl/voltin_seq.sv
// Multi-precision add/subtract sequencer: one 32-bit word per cycle through
// a voltin ripple adder, with the carry chained between words in a register.
module voltin (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic c;

    always_comb begin
        sum = '0;
        c   = cin;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

module voltin_seq #(
    parameter int MAX_WORDS = 8,
    parameter int CW        = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] nwords,
    input  logic          cin_init,
    input  logic          sub,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   a_word,
    input  logic [31:0]   b_word,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   sum_word,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          carry_out,
    output logic          overflow
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] MAXW = CW'(MAX_WORDS);

    logic [1:0]    r_state;
    logic [CW-1:0] r_remaining;
    logic          r_sub;
    logic          r_carry;
    logic          r_ovf_last;
    logic [31:0]   r_sum;
    logic          r_out_valid;
    logic          r_out_last;
    logic          r_carry_out;
    logic          r_overflow;

    logic [CW-1:0] w_nw;
    logic [31:0]   w_bx;
    logic [31:0]   w_sum;
    logic          w_cout;
    logic          w_ovf;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_out_hs;

    assign w_nw = (nwords > MAXW) ? MAXW : nwords;
    assign w_bx = r_sub ? ~b_word : b_word;

    voltin u_add (
        .a    (a_word),
        .b    (w_bx),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    assign w_ovf = (a_word[31] == w_bx[31]) && (w_sum[31] != a_word[31]);

    // remaining == 0 blocks further input while the last word drains
    assign w_in_ready = (r_state == RUN) && (r_remaining != '0)
                      && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_out_hs   = r_out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_sub       <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf_last  <= 1'b0;
            r_sum       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_remaining <= w_nw;
                        r_sub       <= sub;
                        r_carry     <= cin_init ^ sub;
                        r_overflow  <= 1'b0;
                        if (w_nw == '0) begin
                            r_carry_out <= cin_init ^ sub;
                            r_state     <= DONE;
                        end else begin
                            r_carry_out <= 1'b0;
                            r_state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_sum       <= w_sum;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (r_remaining == CW'(1));
                        r_carry     <= w_cout;
                        r_ovf_last  <= w_ovf;
                        r_remaining <= r_remaining - CW'(1);
                    end else if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        if (r_out_last) begin
                            r_out_last  <= 1'b0;
                            r_carry_out <= r_carry;
                            r_overflow  <= r_ovf_last;
                            r_state     <= DONE;
                        end
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign sum_word  = r_sum;
    assign out_last  = r_out_last;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
endmodule

// File: tb/tb_voltin_seq.sv
// Scoreboard bench for voltin_seq: directed vectors push expected words and
// end-of-op flags; monitors pop them on output handshakes and done pulses.
module tb_voltin_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  nwords = '0;
    logic        cin_init = 1'b0;
    logic        sub = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a_word = '0;
    logic [31:0] b_word = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum_word;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        carry_out;
    logic        overflow;

    voltin_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .nwords    (nwords),
        .cin_init  (cin_init),
        .sub       (sub),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_word    (a_word),
        .b_word    (b_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_word  (sum_word),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s;
        logic        l;
    } wexp_t;

    typedef struct {
        logic co;
        logic ov;
        bit   timed;
    } dexp_t;

    wexp_t wq[$];
    dexp_t dq[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    last_hs_cyc = -100;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // output-word monitor
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (wq.size() == 0) begin
                chk("unexpected_word", 32'd1, 32'd0);
            end else begin
                wexp_t e;
                e = wq.pop_front();
                chk("sum_word", sum_word, e.s);
                chk("out_last", {31'd0, out_last}, {31'd0, e.l});
                if (out_last) last_hs_cyc = cyc;
            end
        end
    end

    // done-pulse monitor
    always @(negedge clk) begin
        if (reset && done) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                dexp_t d;
                d = dq.pop_front();
                chk("done_carry_out", {31'd0, carry_out}, {31'd0, d.co});
                chk("done_overflow", {31'd0, overflow}, {31'd0, d.ov});
                if (d.timed) chk("done_latency", cyc, last_hs_cyc + 1);
            end
        end
    end

    task automatic push_w(input logic [31:0] s, input logic l);
        wexp_t e;
        e.s = s;
        e.l = l;
        wq.push_back(e);
    endtask

    task automatic push_d(input logic co, input logic ov, input bit t);
        dexp_t d;
        d.co = co;
        d.ov = ov;
        d.timed = t;
        dq.push_back(d);
    endtask

    task automatic start_op(input logic [3:0] nw, input logic s,
                            input logic ci);
        start = 1'b1;
        nwords = nw;
        sub = s;
        cin_init = ci;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        a_word = a;
        b_word = b;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_outputs",
            {24'd0, in_ready, out_valid, out_last, busy, done,
             carry_out, overflow, 1'b0},
            32'd0);
        chk("rst_sum", sum_word, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: single add
        push_w(32'h6, 1'b1);
        push_d(1'b0, 1'b0, 1'b1);
        start_op(4'd1, 1'b0, 1'b0);
        chk("busy_run", {31'd0, busy}, 32'd1);
        send_word(32'h1, 32'h5);
        wait_idle();
        chk("t1_carry_hold", {31'd0, carry_out}, 32'd0);

        // 2: carry chain
        push_w(32'h0, 1'b0);
        push_w(32'h1, 1'b1);
        push_d(1'b0, 1'b0, 1'b1);
        start_op(4'd2, 1'b0, 1'b0);
        send_word(32'hFFFFFFFF, 32'h1);
        send_word(32'h0, 32'h0);
        wait_idle();

        // 3: subtract
        push_w(32'hFFFFFFFF, 1'b0);
        push_w(32'h0, 1'b1);
        push_d(1'b1, 1'b0, 1'b1);
        start_op(4'd2, 1'b1, 1'b0);
        send_word(32'h0, 32'h1);
        send_word(32'h1, 32'h0);
        wait_idle();
        chk("t3_carry_hold", {31'd0, carry_out}, 32'd1);

        // 4: overflow under backpressure
        push_w(32'h80000000, 1'b1);
        push_d(1'b0, 1'b1, 1'b1);
        start_op(4'd1, 1'b0, 1'b0);
        out_ready = 1'b0;
        send_word(32'h7FFFFFFF, 32'h1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_sum", sum_word, 32'h80000000);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_idle();
        chk("t4_overflow_hold", {31'd0, overflow}, 32'd1);

        // 5a: zero words, done right after start; start clears overflow
        push_d(1'b1, 1'b0, 1'b0);
        start_op(4'd0, 1'b0, 1'b1);
        chk("nw0_done", {31'd0, done}, 32'd1);
        chk("nw0_carry", {31'd0, carry_out}, 32'd1);
        chk("nw0_ovf_clr", {31'd0, overflow}, 32'd0);
        chk("nw0_no_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("nw0_done_pulse", {31'd0, done}, 32'd0);
        chk("nw0_idle", {31'd0, busy}, 32'd0);

        // 5b: nwords=15 clamps to 8 words
        for (int i = 0; i < 8; i++) push_w(32'h11 * i, i == 7);
        push_d(1'b0, 1'b0, 1'b1);
        start_op(4'd15, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_word(32'h10 * i, i);
        chk("clamp_in_ready", {31'd0, in_ready}, 32'd0);
        wait_idle();

        // 6: reset mid-operation discards it
        push_w(32'h2, 1'b0);
        start_op(4'd4, 1'b0, 1'b0);
        send_word(32'h1, 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_outputs",
            {24'd0, in_ready, out_valid, out_last, busy, done,
             carry_out, overflow, 1'b0},
            32'd0);
        chk("midrst_sum", sum_word, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        push_w(32'h6, 1'b1);
        push_d(1'b0, 1'b0, 1'b1);
        start_op(4'd1, 1'b0, 1'b0);
        send_word(32'h1, 32'h5);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        chk("wq_empty", wq.size(), 32'd0);
        chk("dq_empty", dq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
